// File: rtl/spy_playback_sequencer_if.sv
// Bus bundle for the spy playback sequencer: spy memory read/write ports,
// external block-load write input and the playback stream toward the FIFO.
`timescale 1ns/1ps
interface spy_playback_sequencer_if #(
  parameter int DATAWIDTH = 64,
  parameter int MEMWIDTH  = 6
);
  logic                 mem_rd_en;
  logic [MEMWIDTH-1:0]  mem_rd_addr;
  logic [DATAWIDTH:0]   mem_rd_data;
  logic                 ext_wr_en;
  logic [DATAWIDTH:0]   ext_wr_data;
  logic                 mem_wr_en;
  logic [MEMWIDTH-1:0]  mem_wr_addr;
  logic [DATAWIDTH:0]   mem_wr_data;
  logic                 out_valid;
  logic [DATAWIDTH:0]   out_data;
  logic                 out_ready;

  modport master (
    output mem_rd_en, mem_rd_addr,
    input  mem_rd_data,
    input  ext_wr_en, ext_wr_data,
    output mem_wr_en, mem_wr_addr, mem_wr_data,
    output out_valid, out_data,
    input  out_ready
  );

  modport slave (
    input  mem_rd_en, mem_rd_addr,
    output mem_rd_data,
    output ext_wr_en, ext_wr_data,
    input  mem_wr_en, mem_wr_addr, mem_wr_data,
    input  out_valid, out_data,
    output out_ready
  );
endinterface

// File: rtl/spy_playback_sequencer.sv
// Replays an address window of the spy memory into the downstream FIFO once,
// N times or forever, through a credit-managed skid buffer; also block-loads memory.
`timescale 1ns/1ps
module spy_playback_sequencer #(
  parameter int DATAWIDTH    = 64,
  parameter int MEMWIDTH     = 6,
  parameter int READ_LATENCY = 1,
  parameter int LOOPWIDTH    = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [1:0]           mode,
  input  logic [MEMWIDTH-1:0]  start_addr,
  input  logic [MEMWIDTH-1:0]  stop_addr,
  input  logic [LOOPWIDTH-1:0] loop_count,
  output logic                 busy,
  output logic                 done,
  output logic [LOOPWIDTH-1:0] loops_done,
  spy_playback_sequencer_if.master bus
);

  localparam int SKID_D  = READ_LATENCY + 1;
  localparam int SKID_AW = $clog2(SKID_D);
  localparam int CNT_W   = $clog2(SKID_D + 1);
  localparam int CRD_W   = $clog2(2 * SKID_D + 1);

  localparam logic [1:0] M_ONCE  = 2'd1;
  localparam logic [1:0] M_LOOP  = 2'd2;
  localparam logic [1:0] M_WRITE = 2'd3;

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE, S_WRITE} state_t;

  state_t                r_state;
  logic [1:0]            r_mode;
  logic [MEMWIDTH-1:0]   r_start;
  logic [MEMWIDTH-1:0]   r_stop;
  logic [LOOPWIDTH-1:0]  r_loop_cnt;
  logic [MEMWIDTH-1:0]   r_rd_ptr;
  logic [MEMWIDTH-1:0]   r_wr_ptr;
  logic [LOOPWIDTH-1:0]  r_loops;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_wr_en;
  logic [MEMWIDTH-1:0]   r_wr_addr;
  logic [DATAWIDTH:0]    r_wr_data;
  logic [READ_LATENCY-1:0] r_rd_vld_p;
  logic [DATAWIDTH:0]    r_skid [SKID_D];
  logic [SKID_AW-1:0]    r_wptr;
  logic [SKID_AW-1:0]    r_rptr;
  logic [CNT_W-1:0]      r_cnt;

  logic                  w_abort;
  logic                  w_land;
  logic                  w_pop;
  logic [CRD_W-1:0]      w_inflight;
  logic [CRD_W-1:0]      w_used;
  logic                  w_issue;
  logic                  w_pass_end;
  logic [LOOPWIDTH-1:0]  w_loops_nxt;
  logic                  w_last_pass;

  function automatic logic [LOOPWIDTH-1:0] sat_inc(input logic [LOOPWIDTH-1:0] v);
    return (&v) ? v : v + LOOPWIDTH'(1);
  endfunction

  function automatic logic [CRD_W-1:0] popcnt(input logic [READ_LATENCY-1:0] v);
    logic [CRD_W-1:0] s;
    s = '0;
    for (int i = 0; i < READ_LATENCY; i++) s = s + CRD_W'(v[i]);
    return s;
  endfunction

  function automatic logic [SKID_AW-1:0] ptr_inc(input logic [SKID_AW-1:0] p);
    return (p == SKID_AW'(SKID_D - 1)) ? '0 : p + SKID_AW'(1);
  endfunction

  // A word popped this cycle frees its slot for a read issued in the same cycle,
  // which is what lets a full-rate stream run without bubbles.
  assign w_abort     = (r_state != S_IDLE) && (mode != r_mode);
  assign w_land      = r_rd_vld_p[READ_LATENCY-1];
  assign w_pop       = (r_cnt != '0) && bus.out_ready;
  assign w_inflight  = popcnt(r_rd_vld_p);
  assign w_used      = w_inflight + CRD_W'(r_cnt) - CRD_W'(w_pop);
  assign w_issue     = (r_state == S_RUN) && !w_abort && (w_used < CRD_W'(SKID_D));
  assign w_pass_end  = (r_rd_ptr == r_stop);
  assign w_loops_nxt = sat_inc(r_loops);
  assign w_last_pass = (r_mode == M_ONCE) ||
                       ((r_loop_cnt != '0) && (w_loops_nxt == r_loop_cnt));

  assign bus.mem_rd_en   = w_issue;
  assign bus.mem_rd_addr = r_rd_ptr;
  assign bus.mem_wr_en   = r_wr_en;
  assign bus.mem_wr_addr = r_wr_addr;
  assign bus.mem_wr_data = r_wr_data;
  assign bus.out_valid   = (r_cnt != '0);
  assign bus.out_data    = r_skid[r_rptr];
  assign busy            = r_busy;
  assign done            = r_done;
  assign loops_done      = r_loops;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_mode     <= '0;
      r_start    <= '0;
      r_stop     <= '0;
      r_loop_cnt <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_loops    <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
    end else begin
      r_wr_en <= 1'b0;
      if (w_abort) begin
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
        r_done  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (mode == M_ONCE || mode == M_LOOP) begin
              r_mode     <= mode;
              r_start    <= start_addr;
              r_stop     <= stop_addr;
              r_loop_cnt <= loop_count;
              r_rd_ptr   <= start_addr;
              r_loops    <= '0;
              r_busy     <= 1'b1;
              r_state    <= S_RUN;
            end else if (mode == M_WRITE) begin
              r_mode   <= mode;
              r_wr_ptr <= start_addr;
              r_state  <= S_WRITE;
            end
          end
          S_RUN: begin
            if (w_issue) begin
              if (w_pass_end) begin
                r_loops <= w_loops_nxt;
                if (w_last_pass) r_state  <= S_DRAIN;
                else             r_rd_ptr <= r_start;
              end else begin
                r_rd_ptr <= r_rd_ptr + MEMWIDTH'(1);
              end
            end
          end
          S_DRAIN: begin
            if (w_inflight == '0 && r_cnt == '0) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
          S_DONE: ;
          S_WRITE: begin
            r_wr_en <= bus.ext_wr_en;
            if (bus.ext_wr_en) begin
              r_wr_addr <= r_wr_ptr;
              r_wr_data <= bus.ext_wr_data;
              r_wr_ptr  <= r_wr_ptr + MEMWIDTH'(1);
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  // Read-return tag pipeline and skid buffer; an abort drops every tag so
  // returns already on their way from memory are never captured.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rd_vld_p <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_cnt      <= '0;
      for (int i = 0; i < SKID_D; i++) r_skid[i] <= '0;
    end else if (w_abort) begin
      r_rd_vld_p <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_cnt      <= '0;
    end else begin
      r_rd_vld_p[0] <= w_issue;
      for (int i = 1; i < READ_LATENCY; i++) r_rd_vld_p[i] <= r_rd_vld_p[i-1];
      if (w_land) begin
        r_skid[r_wptr] <= bus.mem_rd_data;
        r_wptr         <= ptr_inc(r_wptr);
      end
      if (w_pop) r_rptr <= ptr_inc(r_rptr);
      r_cnt <= r_cnt + CNT_W'(w_land) - CNT_W'(w_pop);
    end
  end

endmodule
